// File: rtl/order_mem.sv
// order_mem: order-book storage responder.
//
// Services one outstanding read, write or clear request at a time over a
// start/valid handshake. Each entry is indexed by order ID and holds a full
// order word plus an occupied bit. Writes and clears return the entry's
// previous contents (read-before-write), so initiators can spot overwrites
// and recover cancelled orders without a second access.
//
// After reset an internal sweep clears every occupied bit. The data array
// itself is never reset.
//
// Ports:
//   clk_in     in   1       clock
//   rst        in   1       synchronous active-high reset
//   start      in   1       request strobe, sampled only while busy=0
//   addr       in   ADDR_W  entry index (order ID)
//   data_w     in   DATA_W  write data
//   is_write   in   1       1 = write request (wins over is_clear)
//   is_clear   in   1       1 = clear request
//   valid      out  1       one-cycle response pulse
//   data_r     out  DATA_W  entry data before the access
//   hit        out  1       entry occupied bit before the access
//   busy       out  1       request not accepted this cycle
//   init_done  out  1       initial clear sweep complete

module order_mem #(
    parameter int unsigned ADDR_W     = 4,   // order ID width; DEPTH = 2**ADDR_W
    parameter int unsigned DATA_W     = 32,  // order word width
    parameter int unsigned RD_LATENCY = 2    // read latency in edges, 1..15
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_w,
    input  logic              is_write,
    input  logic              is_clear,
    output logic              valid,
    output logic [DATA_W-1:0] data_r,
    output logic              hit,
    output logic              busy,
    output logic              init_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
    // Countdown starts at RD_LATENCY-1 so the capture lands on edge E(RD_LATENCY).
    localparam logic [3:0] LatInit = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {StInit, StIdle, StAccess, StResp} state_e;
    typedef enum logic [1:0] {OpRead, OpWrite, OpClear} op_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    op_e               op_q;
    logic [3:0]        lat_q;
    logic [DATA_W-1:0] data_r_q;
    logic              hit_q;
    logic              init_done_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  occ_q;

    logic accept;
    logic sweep;
    logic sweep_last;
    logic capture;
    logic do_write;
    logic do_clear;
    logic lat_dec;

    // Next state and datapath strobes.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        sweep      = 1'b0;
        sweep_last = 1'b0;
        capture    = 1'b0;
        do_write   = 1'b0;
        do_clear   = 1'b0;
        lat_dec    = 1'b0;

        case (state_q)
            StInit: begin
                sweep = 1'b1;
                if (cnt_q == LastIdx) begin
                    sweep_last = 1'b1;
                    state_d    = StIdle;
                end
            end
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // Writes and clears always finish at E1; reads wait out the countdown.
                if (op_q != OpRead || lat_q == 4'd0) begin
                    capture  = 1'b1;
                    do_write = (op_q == OpWrite);
                    do_clear = (op_q == OpClear);
                    state_d  = StResp;
                end else begin
                    lat_dec = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Reset aborts everything in flight, including array updates on this edge.
        if (rst) begin
            state_d    = StInit;
            accept     = 1'b0;
            sweep      = 1'b0;
            sweep_last = 1'b0;
            capture    = 1'b0;
            do_write   = 1'b0;
            do_clear   = 1'b0;
            lat_dec    = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        state_q <= state_d;
    end

    // Registers with reset values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q       <= '0;
            data_r_q    <= '0;
            hit_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            if (sweep) begin
                cnt_q <= cnt_q + ADDR_W'(1);
            end
            if (sweep_last) begin
                init_done_q <= 1'b1;
            end
            if (capture) begin
                data_r_q <= mem[addr_q];
                hit_q    <= occ_q[addr_q];
            end
        end
    end

    // Request latch and read countdown; no reset needed, only used after accept.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            addr_q  <= addr;
            wdata_q <= data_w;
            if (is_write) begin
                op_q <= OpWrite;
            end else if (is_clear) begin
                op_q <= OpClear;
            end else begin
                op_q <= OpRead;
            end
            lat_q <= LatInit;
        end else if (lat_dec) begin
            lat_q <= lat_q - 4'd1;
        end
    end

    // Data array: never reset, written only by completed write requests.
    always_ff @(posedge clk_in) begin
        if (do_write) begin
            mem[addr_q] <= wdata_q;
        end
    end

    // Occupied bits: cleared by the sweep, otherwise updated by writes/clears.
    always_ff @(posedge clk_in) begin
        if (sweep) begin
            occ_q[cnt_q] <= 1'b0;
        end
        if (do_write) begin
            occ_q[addr_q] <= 1'b1;
        end
        if (do_clear) begin
            occ_q[addr_q] <= 1'b0;
        end
    end

    assign valid     = (state_q == StResp);
    assign busy      = (state_q != StIdle);
    assign data_r    = data_r_q;
    assign hit       = hit_q;
    assign init_done = init_done_q;

endmodule
